// File: rtl/mpadd_seq.sv
// Multi-precision add/sub sequencer: one 16-bit slice per cycle, LSW first.
// Optional MPADD_SAT_EN: saturate s on signed overflow at completion.
module mpadd_seq #(
  parameter int NWORDS = 4,
  localparam int W  = 16 * NWORDS,
  localparam int IW = $clog2(NWORDS)
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [15:0]     a_sl;
  logic [15:0]     b_sl;
  logic [16:0]     sum;
  logic            c15;
  logic            ovf_w;

  assign a_sl  = a_q[idx_q*16 +: 16];
  assign b_sl  = b_q[idx_q*16 +: 16] ^ {16{sub_q}};
  assign sum   = {1'b0, a_sl} + {1'b0, b_sl} + {16'b0, carry_q};
  // carry into bit 15 recovered from the sum bit
  assign c15   = sum[15] ^ a_sl[15] ^ b_sl[15];
  assign ovf_w = c15 ^ sum[16];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d[idx_q*16 +: 16] = sum[15:0];
        carry_d = sum[16];
        if (idx_q == IW'(NWORDS - 1)) begin
          cout_d  = sum[16];
          ovf_d   = ovf_w;
          state_d = DONE;
`ifdef MPADD_SAT_EN
          if (ovf_w) begin
            s_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}}
                           : {1'b0, {(W-1){1'b1}}};
          end
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mpadd_seq.sv
// Directed bench for mpadd_seq (NWORDS=4, W=64).
// Expected values hand-computed; MPADD_SAT_EN selects overflow result.
module tb_mpadd_seq;

  logic        clk;
  logic        clrn;
  logic        start;
  logic        sub;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] s;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  mpadd_seq #(.NWORDS(4)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept an op, check busy for 4 cycles, end in the done cycle.
  task automatic run_op(input string tag,
                        input logic [63:0] ia,
                        input logic [63:0] ib,
                        input logic        isub,
                        input logic [63:0] es,
                        input logic        ec,
                        input logic        eo);
    a = ia;
    b = ib;
    sub = isub;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
      chk({tag, "_nodone"}, {63'b0, done}, 64'd0);
      tick();
    end
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    chk({tag, "_idle"}, {63'b0, busy}, 64'd0);
    chk({tag, "_s"}, s, es);
    chk({tag, "_cout"}, {63'b0, cout}, {63'b0, ec});
    chk({tag, "_ovf"}, {63'b0, ovf}, {63'b0, eo});
  endtask

  logic [63:0] sat_exp;
  int          ndone;
  int          done_at;
  logic [63:0] s_at;

  initial begin
`ifdef MPADD_SAT_EN
    sat_exp = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    sat_exp = 64'h8000_0000_0000_0000;
`endif
    clrn  = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_s", s, 64'd0);
    chk("rst_cout", {63'b0, cout}, 64'd0);
    chk("rst_ovf", {63'b0, ovf}, 64'd0);
    clrn = 1'b1;
    tick();

    run_op("t1_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
           64'd0, 1'b1, 1'b0);
    tick();
    chk("t1_done_pulse", {63'b0, done}, 64'd0);
    chk("t1_s_hold", s, 64'd0);

    run_op("t2_borrow", 64'd0, 64'd1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    tick();

    run_op("t3_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
           sat_exp, 1'b0, 1'b1);
    tick();

    // reset while RUN at idx 2; ovf still holds 1 from t3
    a = 64'h0001_0002_0003_0004;
    b = 64'h0010_0020_0030_0040;
    sub = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t6_partial", {32'b0, s[31:0]}, 64'h0000_0000_0033_0044);
    chk("t6_pre_ovf", {63'b0, ovf}, 64'd1);
    clrn = 1'b0;
    #1;
    chk("t6_busy", {63'b0, busy}, 64'd0);
    chk("t6_s", s, 64'd0);
    chk("t6_ovf", {63'b0, ovf}, 64'd0);
    chk("t6_cout", {63'b0, cout}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("t6_nodone", 64'(ndone), 64'd0);
    clrn = 1'b1;
    tick();
    run_op("t6_fresh", 64'h0001_0002_0003_0004,
           64'h0010_0020_0030_0040, 1'b0,
           64'h0011_0022_0033_0044, 1'b0, 1'b0);
    tick();

    // back-to-back: start held in the done cycle
    run_op("t4_first", 64'd10, 64'd20, 1'b0, 64'd30, 1'b0, 1'b0);
    a = 64'd5;
    b = 64'd3;
    sub = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_at = 0;
    for (int i = 1; i <= 6; i++) begin
      if (done && done_at == 0) done_at = i;
      if (i < 6) tick();
    end
    chk("t4_gap", 64'(done_at), 64'd5);
    chk("t4_s", s, 64'd2);
    chk("t4_cout", {63'b0, cout}, 64'd1);
    chk("t4_ovf", {63'b0, ovf}, 64'd0);
    tick();

    // start pulse mid-RUN must be ignored
    a = 64'd100;
    b = 64'd200;
    sub = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    done_at = 0;
    s_at = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) begin
        a = 64'd1;
        b = 64'd1;
        sub = 1'b1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        done_at = i;
        s_at = s;
      end
    end
    chk("t5_ndone", 64'(ndone), 64'd1);
    chk("t5_lat", 64'(done_at), 64'd4);
    chk("t5_s", s_at, 64'd300);
    chk("t5_s_hold", s, 64'd300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
